// File: rtl/mst_fifo_pref_pkg.sv
// Shared constants and types for the prefetch FIFO and the write state machine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   PREF_W     : width of one prefetch word (byte-enable + 16 data bits)
//   EMPTY_WORD : value shown on the head port while the buffer is empty
//   BE_FULL    : byte-enable value stamped on every generated word
package mst_fifo_pref_pkg;

  localparam int              PREF_W     = 17;
  localparam int              LVL_W      = 5;
  localparam logic [PREF_W-1:0] EMPTY_WORD = 17'h1FFFF;
  localparam logic            BE_FULL    = 1'b1;

  typedef struct packed {
    logic        be;
    logic [15:0] dat;
  } pref_word_t;

  // Build a buffer word from a generator value.
  function automatic pref_word_t mk_word(input logic [15:0] d);
    pref_word_t w;
    w.be  = BE_FULL;
    w.dat = d;
    return w;
  endfunction

endpackage

// File: rtl/mst_fifo_pref_if.sv
// Handshake bundle between the consumer (write state machine) and the prefetch FIFO.
// Latency: n/a (wires only).
// Backpressure: consumer pops with prefreq while prefena is high; no ready path back.
//   prefena/prefreq/pref_clr : consumer -> fifo
//   prefdout/pref_lvl/pref_err : fifo -> consumer
interface mst_fifo_pref_if;
  import mst_fifo_pref_pkg::*;

  logic              prefena;
  logic              prefreq;
  logic              pref_clr;
  logic [PREF_W-1:0] prefdout;
  logic [LVL_W-1:0]  pref_lvl;
  logic              pref_err;

  modport master (
    output prefena, prefreq, pref_clr,
    input  prefdout, pref_lvl, pref_err
  );

  modport slave (
    input  prefena, prefreq, pref_clr,
    output prefdout, pref_lvl, pref_err
  );

endinterface

// File: rtl/mst_fifo_pref_ram.sv
// DEPTH x PREF_W storage for the prefetch FIFO; contents are not reset.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the controller decides when to write.
//   clk, we, waddr, wdat : synchronous write port
//   raddr, rdat          : asynchronous read port
module mst_pref_ram
  import mst_fifo_pref_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PREF_W-1:0] wdat,
  input  logic [AW-1:0]     raddr,
  output logic [PREF_W-1:0] rdat
);

  logic [PREF_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/mst_fifo_pref.sv
// Self-filling prefetch FIFO fed by an incrementing 16-bit pattern generator.
// Latency: show-ahead head word, zero read latency; a pop is visible next cycle.
// Backpressure: generator stalls while full unless a pop frees a slot that cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   pif        : slave side of mst_fifo_pref_if (prefena/prefreq/pref_clr in,
//                prefdout/pref_lvl/pref_err out)
module mst_fifo_pref
  import mst_fifo_pref_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [15:0] SEED  = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  mst_fifo_pref_if.slave pif
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LVL_W-1:0]  lvl;
  logic [15:0]       gen;
  logic              err;

  logic              empty;
  logic              full;
  logic              req_act;
  logic              pop;
  logic              push;
  logic              wr_en;
  logic [PREF_W-1:0] head;

  assign empty   = (lvl == '0);
  assign full    = (lvl == LVL_MAX);
  assign req_act = pif.prefreq & pif.prefena;
  assign pop     = req_act & ~empty;
  // A pop frees the slot the generator refills in the same cycle.
  assign push    = ~full | pop;
  assign wr_en   = push & ~pif.pref_clr;

  mst_pref_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdat  (mk_word(gen)),
    .raddr (rptr),
    .rdat  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      gen  <= SEED;
      err  <= 1'b0;
    end else if (pif.pref_clr) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      gen  <= SEED;
      err  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
        gen  <= gen + 16'd1;
      end
      if (pop) rptr <= rptr + AW'(1);
      // Every pop is paired with a write, so the level only ever grows here.
      if (push && !pop) lvl <= lvl + LVL_W'(1);
      if (req_act && empty) err <= 1'b1;
    end
  end

  assign pif.prefdout = empty ? EMPTY_WORD : head;
  assign pif.pref_lvl = lvl;
  assign pif.pref_err = err;

endmodule

// File: tb/tb_mst_fifo_pref.sv
module tb_mst_fifo_pref;

  localparam int          DEPTH = 4;
  localparam logic [15:0] SEED0 = 16'h0000;

  logic clk;
  logic rst_n;

  mst_fifo_pref_if pif ();
  mst_fifo_pref_if pif2 ();

  mst_fifo_pref #(.DEPTH(DEPTH), .SEED(SEED0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  mst_fifo_pref #(.DEPTH(DEPTH), .SEED(16'hFFFE)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic        req;
    logic        clr;
    logic [4:0]  lvl;
    logic [16:0] dout;
    logic        err;
  } vec_t;

  vec_t        tv[$];
  logic [16:0] m_q[$];
  logic [15:0] m_gen;
  int          vectors;
  int          miscompares;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic ena, input logic req, input logic clr,
                              input logic [4:0] lvl, input logic [16:0] dout,
                              input logic err);
    vec_t v;
    v.ena = ena; v.req = req; v.clr = clr;
    v.lvl = lvl; v.dout = dout; v.err = err;
    tv.push_back(v);
  endfunction

  // Drive one cycle of stimulus; the scoreboard predicts writes and checks pops.
  task automatic step(input logic ena, input logic req, input logic clr);
    logic do_pop;
    logic do_push;
    logic [16:0] exp_word;
    pif.prefena  = ena;
    pif.prefreq  = req;
    pif.pref_clr = clr;
    if (clr) begin
      m_q.delete();
      m_gen = SEED0;
    end else begin
      do_pop  = ena && req && (m_q.size() > 0);
      do_push = (m_q.size() < DEPTH) || do_pop;
      if (do_pop) begin
        exp_word = m_q.pop_front();
        chk("sb_pop_word", 32'(pif.prefdout), 32'(exp_word));
      end
      if (do_push) begin
        m_q.push_back({1'b1, m_gen});
        m_gen = m_gen + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("sb_lvl", 32'(pif.pref_lvl), 32'(m_q.size()));
  endtask

  logic [16:0] exp2 [6];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    pif.prefena  = 1'b0;
    pif.prefreq  = 1'b0;
    pif.pref_clr = 1'b0;
    pif2.prefena  = 1'b0;
    pif2.prefreq  = 1'b0;
    pif2.pref_clr = 1'b0;
    m_q.delete();
    m_gen = SEED0;
    exp2 = '{17'h1FFFE, 17'h1FFFF, 17'h10000, 17'h10001, 17'h10002, 17'h10003};

    // Fill after reset, no requests.
    add(0, 0, 0, 5'd1, 17'h10000, 0);
    add(0, 0, 0, 5'd2, 17'h10000, 0);
    add(0, 0, 0, 5'd3, 17'h10000, 0);
    add(0, 0, 0, 5'd4, 17'h10000, 0);
    add(0, 0, 0, 5'd4, 17'h10000, 0);
    // Ten back-to-back pops while full.
    for (int k = 1; k <= 10; k++) add(1, 1, 0, 5'd4, 17'(17'h10000 + k), 0);
    // prefreq ignored while prefena is low.
    for (int k = 0; k < 5; k++) add(0, 1, 0, 5'd4, 17'h1000A, 0);
    // Clear wins over a simultaneous pop, then refill from SEED.
    add(1, 1, 1, 5'd0, 17'h1FFFF, 0);
    add(0, 0, 0, 5'd1, 17'h10000, 0);
    add(0, 0, 0, 5'd2, 17'h10000, 0);
    // Underflow on empty buffer sets a sticky error until clear.
    add(0, 0, 1, 5'd0, 17'h1FFFF, 0);
    add(1, 1, 0, 5'd1, 17'h10000, 1);
    add(1, 1, 0, 5'd1, 17'h10001, 1);
    add(0, 0, 0, 5'd2, 17'h10001, 1);
    add(0, 0, 0, 5'd3, 17'h10001, 1);
    add(0, 0, 1, 5'd0, 17'h1FFFF, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", 32'(pif.prefdout), 32'(17'h1FFFF));
    chk("reset_lvl",  32'(pif.pref_lvl), 32'd0);
    chk("reset_err",  32'(pif.pref_err), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].ena, tv[i].req, tv[i].clr);
      chk($sformatf("vec%0d_lvl", i),  32'(pif.pref_lvl), 32'(tv[i].lvl));
      chk($sformatf("vec%0d_dout", i), 32'(pif.prefdout), 32'(tv[i].dout));
      chk($sformatf("vec%0d_err", i),  32'(pif.pref_err), 32'(tv[i].err));
    end

    // Reset pulsed mid-burst with the error flag set.
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("preburst_err", 32'(pif.pref_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(pif.prefdout), 32'(17'h1FFFF));
    chk("midrst_lvl",  32'(pif.pref_lvl), 32'd0);
    chk("midrst_err",  32'(pif.pref_err), 32'd0);
    m_q.delete();
    m_gen = SEED0;
    pif.prefena = 1'b0;
    pif.prefreq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("refill_lvl",  32'(pif.pref_lvl), 32'd2);
    chk("refill_dout", 32'(pif.prefdout), 32'(17'h10000));

    // Generator wrap on the second instance.
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("wrap_full_lvl", 32'(pif2.pref_lvl), 32'd4);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wrap_word%0d", k), 32'(pif2.prefdout), 32'(exp2[k]));
      pif2.prefena = 1'b1;
      pif2.prefreq = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("wrap_lvl", 32'(pif2.pref_lvl), 32'd4);
    chk("wrap_err", 32'(pif2.pref_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
